// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM state encoding and the round-robin selection function.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_DONE
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int MAX_REQ            = 8;
  localparam int PTR_W              = 3;

  // Walking from the farthest candidate back to the nearest leaves the
  // requester closest after last_ptr as the single winner.
  function automatic logic [MAX_REQ-1:0] rr_next(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   last_ptr,
    input int                 num_req
  );
    logic [MAX_REQ-1:0] gnt;
    int                 idx;
    gnt = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = (int'(last_ptr) + k) % num_req;
        if (valid[idx[PTR_W-1:0]]) begin
          gnt = MAX_REQ'(1) << idx[PTR_W-1:0];
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_priority.sv
// Combinational rotate-priority encoder.
// Picks the first valid requester after last_ptr, wrapping modulo NUM_REQ.
module rr_priority
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  logic [MAX_REQ-1:0] w_valid8;
  logic [MAX_REQ-1:0] w_gnt8;

  always_comb begin
    w_valid8              = '0;
    w_valid8[NUM_REQ-1:0] = valid;
  end

  assign w_gnt8 = rr_next(w_valid8, last_ptr, NUM_REQ);
  assign gnt    = w_gnt8[NUM_REQ-1:0];
  assign any    = |w_gnt8;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters,
// round-robin at packet granularity, one byte per send/busy handshake.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          active,
  output logic                          tx_send,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_busy
);

  arb_state_t              r_state;
  logic [NUM_REQ-1:0]      r_grant;
  logic [DATA_WIDTH-1:0]   r_txDin;
  logic                    r_lastQ;
  logic [PTR_W-1:0]        r_lastPtr;

  logic [NUM_REQ-1:0]      w_rrGnt;
  logic                    w_rrAny;
  logic [DATA_WIDTH-1:0]   w_selData;
  logic [PTR_W-1:0]        w_gntIdx;
  logic                    w_selValid;
  logic                    w_selLast;

  rr_priority #(
    .NUM_REQ (NUM_REQ)
  ) u_rrPriority (
    .valid    (req_valid),
    .last_ptr (r_lastPtr),
    .gnt      (w_rrGnt),
    .any      (w_rrAny)
  );

  // One-hot mux of the owner's byte; the owner's index becomes last_ptr
  // once its packet finishes.
  always_comb begin
    w_selData = '0;
    w_gntIdx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_selData = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_gntIdx  = PTR_W'(i);
      end
    end
  end

  assign w_selValid = |(req_valid & r_grant);
  assign w_selLast  = |(req_last & r_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_txDin   <= '0;
      r_lastQ   <= 1'b0;
      r_lastPtr <= PTR_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (!tx_busy && w_rrAny) begin
            r_grant <= w_rrGnt;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_selValid) begin
            r_txDin <= w_selData;
            r_lastQ <= w_selLast;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (tx_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // The next grant is only ever computed from IDLE, so a finished
          // packet always costs at least one idle cycle.
          if (!tx_busy) begin
            if (r_lastQ) begin
              r_lastPtr <= w_gntIdx;
              r_grant   <= '0;
              r_state   <= IDLE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == LOAD) ? r_grant : '0;
  assign grant     = r_grant;
  assign active    = |r_grant;
  assign tx_send   = (r_state == SEND);
  assign tx_din    = r_txDin;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a TX model whose busy rises one
// cycle after tx_send and stays high for 100 cycles.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  reqValid = '0;
  logic [3:0]  reqLast = '0;
  logic [31:0] reqData = '0;
  logic        txBusy = 1'b0;
  logic [3:0]  reqReady;
  logic [3:0]  grant;
  logic        active;
  logic        txSend;
  logic [7:0]  txDin;

  int          checksTotal = 0;
  int          checksPassed = 0;
  int          busyCnt = 0;
  logic [11:0] sentLog[$];
  logic [3:0]  grantLog[$];
  logic [3:0]  prevGrant = '0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_data  (reqData),
    .req_last  (reqLast),
    .req_ready (reqReady),
    .grant     (grant),
    .active    (active),
    .tx_send   (txSend),
    .tx_din    (txDin),
    .tx_busy   (txBusy)
  );

  // TX core model; logs every byte it starts as {grant, byte}.
  always @(posedge clk) begin
    if (txBusy) begin
      if (busyCnt == 1) txBusy <= 1'b0;
      busyCnt <= busyCnt - 1;
    end else if (txSend) begin
      txBusy  <= 1'b1;
      busyCnt <= 100;
      sentLog.push_back({grant, txDin});
    end
  end

  always @(negedge clk) begin
    if (grant != prevGrant && grant != 4'd0) grantLog.push_back(grant);
    prevGrant = grant;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [7:0] d, input logic l);
    reqValid[idx[1:0]]             = v;
    reqLast[idx[1:0]]              = l;
    reqData[{idx[1:0], 3'b000} +: 8] = d;
  endtask

  task automatic waitReady(input int idx);
    int n;
    n = 0;
    while (!reqReady[idx[1:0]] && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", 32'(reqReady[idx[1:0]]), 32'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((grant != 4'd0 || txBusy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", 32'(grant), 32'd0);
  endtask

  // Presents each byte until accepted; bytes[7:0] goes first.
  task automatic sendPacket(input int idx, input logic [31:0] bytes, input int len);
    for (int k = 0; k < len; k++) begin
      applyStimulus(idx, 1'b1, bytes[k*8 +: 8], (k == len - 1));
      waitReady(idx);
      @(negedge clk);
    end
    applyStimulus(idx, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int n;

    repeat (2) @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_send", 32'(txSend), 32'd0);
    checkOutput("rst_din", 32'(txDin), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte from requester 2.
    applyStimulus(2, 1'b1, 8'hA5, 1'b1);
    @(negedge clk);
    checkOutput("single_grant", 32'(grant), 32'h4);
    checkOutput("single_ready", 32'(reqReady), 32'h4);
    checkOutput("single_active", 32'(active), 32'd1);
    checkOutput("single_send_early", 32'(txSend), 32'd0);
    @(negedge clk);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    checkOutput("single_ready_pulse", 32'(reqReady), 32'd0);
    checkOutput("single_send", 32'(txSend), 32'd1);
    checkOutput("single_din", 32'(txDin), 32'hA5);
    @(negedge clk);
    checkOutput("single_send_hold", 32'(txSend), 32'd1);
    checkOutput("single_din_hold", 32'(txDin), 32'hA5);
    @(negedge clk);
    checkOutput("single_send_drop", 32'(txSend), 32'd0);
    n = 0;
    while (txBusy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("single_grant_hold", 32'(grant), 32'h4);
    @(negedge clk);
    checkOutput("single_grant_clear", 32'(grant), 32'd0);
    checkOutput("single_active_clear", 32'(active), 32'd0);

    // Locked 3-byte packet from requester 1 while requester 0 waits.
    sentLog.delete();
    grantLog.delete();
    applyStimulus(1, 1'b1, 8'h48, 1'b0);
    @(negedge clk);
    checkOutput("lock_grant", 32'(grant), 32'h2);
    applyStimulus(0, 1'b1, 8'h55, 1'b1);
    sendPacket(1, 32'h000A4948, 3);
    sendPacket(0, 32'h00000055, 1);
    waitIdle();
    checkOutput("lock_bytes", 32'(sentLog.size()), 32'd4);
    checkOutput("lock_b0", 32'(sentLog[0]), 32'h248);
    checkOutput("lock_b1", 32'(sentLog[1]), 32'h249);
    checkOutput("lock_b2", 32'(sentLog[2]), 32'h20A);
    checkOutput("lock_b3", 32'(sentLog[3]), 32'h155);
    checkOutput("lock_grants", 32'(grantLog.size()), 32'd2);
    checkOutput("lock_g1", 32'(grantLog[1]), 32'h1);

    // Asynchronous reset while a 3-byte packet from requester 3 is in WAIT_DONE.
    applyStimulus(3, 1'b1, 8'h31, 1'b0);
    waitReady(3);
    @(negedge clk);
    n = 0;
    while (!(txBusy && !txSend) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_grant_pre", 32'(grant), 32'h8);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_grant", 32'(grant), 32'd0);
    checkOutput("mid_active", 32'(active), 32'd0);
    checkOutput("mid_ready", 32'(reqReady), 32'd0);
    checkOutput("mid_send", 32'(txSend), 32'd0);
    checkOutput("mid_din", 32'(txDin), 32'd0);
    applyStimulus(3, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sentLog.delete();
    grantLog.delete();

    // Round-robin with every requester holding a 1-byte packet.
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 8'(8'h10 + i), 1'b1);
    n = 0;
    while (grantLog.size() < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rr_grants_seen", 32'(grantLog.size()), 32'd5);
    n = 0;
    while (reqReady != 4'd0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 8'h00, 1'b0);
    waitIdle();
    checkOutput("rr_g0", 32'(grantLog[0]), 32'h1);
    checkOutput("rr_g1", 32'(grantLog[1]), 32'h2);
    checkOutput("rr_g2", 32'(grantLog[2]), 32'h4);
    checkOutput("rr_g3", 32'(grantLog[3]), 32'h8);
    checkOutput("rr_g4", 32'(grantLog[4]), 32'h1);
    checkOutput("rr_b0", 32'(sentLog[0]), 32'h110);
    checkOutput("rr_b1", 32'(sentLog[1]), 32'h211);
    checkOutput("rr_b2", 32'(sentLog[2]), 32'h412);
    checkOutput("rr_b3", 32'(sentLog[3]), 32'h813);
    checkOutput("rr_b4", 32'(sentLog[4]), 32'h110);

    // Requester 1 stalls 50 cycles between its two bytes.
    sentLog.delete();
    applyStimulus(1, 1'b1, 8'h61, 1'b0);
    waitReady(1);
    @(negedge clk);
    applyStimulus(1, 1'b0, 8'h61, 1'b0);
    waitReady(1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c % 10 == 9) begin
        checkOutput("stall_send", 32'(txSend), 32'd0);
        checkOutput("stall_grant", 32'(grant), 32'h2);
        checkOutput("stall_ready", 32'(reqReady), 32'h2);
      end
    end
    applyStimulus(1, 1'b1, 8'h62, 1'b1);
    @(negedge clk);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    checkOutput("stall_resume_send", 32'(txSend), 32'd1);
    checkOutput("stall_resume_din", 32'(txDin), 32'h62);
    waitIdle();
    checkOutput("stall_b0", 32'(sentLog[0]), 32'h261);
    checkOutput("stall_b1", 32'(sentLog[1]), 32'h262);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between `NUM_REQ` byte-stream requesters. Each requester can send a packet of one or more bytes. The block arbitrates round-robin at packet granularity and hands bytes to the transmitter one at a time over its send/busy handshake. It sits between the application sources (button/switch front end, status reporters) and the UART TX core in the top level.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width passed to the transmitter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `req_valid`  in  NUM_REQ  requester i has a byte on `req_data` slice i.
- `req_data`  in  NUM_REQ*DATA_WIDTH  byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  the byte presented is the final byte of requester i's packet.
- `req_ready`  out  NUM_REQ  one-hot; a byte is accepted on `req_valid[i] & req_ready[i]`.
- `grant`  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- `active`  out  1  high whenever `grant` is nonzero.
- `tx_send`  out  1  send request to the UART TX core.
- `tx_din`  out  DATA_WIDTH  byte to transmit; stable while `tx_send` is high.
- `tx_busy`  in  1  UART TX core is transmitting.

## Operation
FSM states are IDLE, LOAD, SEND and WAIT_DONE.
- **IDLE**
  - Enter LOAD when `tx_busy==0` and any `req_valid` is high.
  - Set `grant` to the first valid requester, searching from `last_ptr+1` modulo `NUM_REQ`.
  - Stay in IDLE while `tx_busy` is high.
- **LOAD**
  - `req_ready[g]` is high combinationally while in LOAD.
  - If `req_valid[g]`: register `req_data[g]` into `tx_din` and `req_last[g]` into `last_q`, then go to SEND.
  - Otherwise stay in LOAD. The packet stays locked and no other requester is served.
- **SEND**
  - `tx_send` is high, decoded from state.
  - Go to WAIT_DONE on the first cycle `tx_busy==1`.
- **WAIT_DONE**
  - `tx_send` is low. Wait for `tx_busy==0`.
  - Then, if `last_q`: set `last_ptr<=g`, clear `grant` and go to IDLE.
  - Otherwise go to LOAD.
- **Round-robin**
  - `last_ptr` updates only at the end of a packet.
  - After reset `last_ptr = NUM_REQ-1`, so requester 0 has the highest priority first.
- **Requester-side rules**
  - Changes to `req_valid`/`req_data` of non-granted requesters have no effect.
  - A granted requester dropping `req_valid` mid-packet stalls in LOAD indefinitely.
- **Packet length**
  - A single-byte packet has `req_last=1` on its only byte.
  - Packet length is unbounded.

## Timing
- **Reset values:** `grant=0`, `active=0`, `req_ready=0`, `tx_send=0`, `tx_din=0`, state IDLE, `last_ptr=NUM_REQ-1`, `last_q=0`.
- **Reset mid-operation:** all of the above apply immediately, without waiting for a clock.
  - Any partially sent packet is abandoned.
  - The TX core's in-flight frame is not the arbiter's concern.
- **Latency:**
  - Request seen in IDLE at cycle 0: `grant` valid at cycle 1 (LOAD, `req_ready` high).
  - Accept at cycle 1: `tx_send` high from cycle 2.
- **Handshake with the TX core:**
  - `tx_send` holds until `tx_busy` is seen high; `tx_din` never changes while in SEND.
  - If `tx_busy` is high in the same cycle SEND is entered, the transition occurs on that cycle, giving a one-cycle send pulse.
- **Between bytes of a packet:** minimum one LOAD cycle after `tx_busy` falls.
- **Between packets:** minimum one IDLE cycle. A new grant is computed in IDLE, never directly in WAIT_DONE.
- **Simultaneous valid on all requesters:** served strictly in rotation, one packet each.

## Structure
- **Package `uart_tx_arb_pkg`:**
  - state enum `arb_state_t` {IDLE, LOAD, SEND, WAIT_DONE};
  - default `DATA_WIDTH`;
  - function `rr_next(valid, last_ptr)` returning a one-hot vector.
- **Sub-module `rr_priority`:** combinational rotate-priority encoder.
  - Inputs: `valid`[NUM_REQ], `last_ptr`.
  - Outputs: one-hot `gnt` and an `any` flag.
  - The top-level FSM registers its output.

## Test plan
Use a bench TX model whose `tx_busy` rises 1 cycle after `tx_send` and stays high for 100 cycles.
- **Reset mid-packet:** assert `rst` asynchronously, between clock edges, during WAIT_DONE of a 3-byte packet. All outputs must go to reset values immediately; after release, requester 0 is granted first.
- **Single byte:** requester 2 sends 0xA5 with `last=1`. Required response:
  - `req_ready[2]` pulses one cycle;
  - `tx_din=0xA5` with `tx_send` high until `tx_busy`;
  - `grant` returns to 0 one cycle after `tx_busy` falls.
- **Locked packet:** requester 1 sends the 3-byte packet 0x48,0x49,0x0A while requester 0 is valid throughout. All three bytes go out in order before `grant[0]` asserts.
- **Round-robin fairness:** all 4 requesters hold 1-byte packets 0x10,0x11,0x12,0x13 valid continuously. Grant order is 0,1,2,3,0. No requester is granted twice before all others are served.
- **Stall:** the granted requester drops `req_valid` for 50 cycles mid-packet. Required response:
  - the FSM stays in LOAD and `tx_send` stays 0;
  - `grant` is unchanged;
  - transmission resumes one cycle after `req_valid` returns.
